// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- Common Data Bus arbiter.
//
// Picks one completed result per slot from N_SRC reservation stations and
// drives the shared CDB. Each accepted result produces a one-cycle-high
// broadcast, and the following cycle is always low. Consumers detect the
// broadcast on its edge, so two back-to-back results must never merge into
// one long high pulse.
//
// Build option:
//   CDB_ARB_FIXED_PRIO_EN  defined   -> fixed priority (lowest index wins),
//                                       and there is no pointer register
//                          undefined -> round-robin (default)
//
// Ports:
//   clk, rst_n         clock (rising edge); asynchronous active-low reset
//   in_req[N]          per-source result-ready request
//   in_tag/val/icc     per-source result; source i sits at [i*W +: W]
//   in_icc_wr[N]       source's op writes ICC
//   out_ack[N]         one-cycle accept pulse to the granted source
//   out_CDB_*          broadcast pulse, tag and value (tag/value hold)
//   out_ICC_flags/wr   architectural ICC and its write pulse
//   out_grant_idx      last granted source
//   out_drop_cnt       saturating count of INVALID_TAG requests dropped
module cdb_arbiter #(
    parameter int N_SRC  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}},
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC-1:0]          in_req,
    input  logic [N_SRC*TAG_W-1:0]    in_tag,
    input  logic [N_SRC*DATA_W-1:0]   in_val,
    input  logic [N_SRC*4-1:0]        in_icc,
    input  logic [N_SRC-1:0]          in_icc_wr,
    output logic [N_SRC-1:0]          out_ack,
    output logic                      out_CDB_broadcast,
    output logic [TAG_W-1:0]          out_CDB_tag,
    output logic [DATA_W-1:0]         out_CDB_val,
    output logic [3:0]                out_ICC_flags,
    output logic                      out_ICC_wr,
    output logic [IDX_W-1:0]          out_grant_idx,
    output logic [7:0]                out_drop_cnt
);

    typedef enum logic [1:0] {IDLE, BCAST, DROP} state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   ack_q, ack_d;
    logic               bcast_q, bcast_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [DATA_W-1:0]  val_q, val_d;
    logic [3:0]         icc_q, icc_d;
    logic               icc_wr_q, icc_wr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [7:0]         drop_q, drop_d;
`ifndef CDB_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

    // Winner selection, plus the winner's fields pulled out of the flat buses.
    logic [IDX_W-1:0]         win_idx;
    logic [N_SRC-1:0]         req_sh, icc_wr_sh;
    logic [N_SRC*TAG_W-1:0]   tag_sh;
    logic [N_SRC*DATA_W-1:0]  val_sh;
    logic [N_SRC*4-1:0]       icc_sh;

    always_comb begin
        int j;
        win_idx = '0;
`ifdef CDB_ARB_FIXED_PRIO_EN
        // Scan from the top down, so the lowest set index is written last.
        for (int k = N_SRC - 1; k >= 0; k--) begin
            req_sh = in_req >> k;
            if (req_sh[0]) win_idx = IDX_W'(k);
        end
`else
        // Scan the offsets from far to near, starting just after the pointer.
        // The nearest requester (with wrap-around) is written last and wins.
        for (int off = N_SRC; off >= 1; off--) begin
            j = (int'(ptr_q) + off) % N_SRC;
            req_sh = in_req >> j;
            if (req_sh[0]) win_idx = IDX_W'(j);
        end
`endif
        j         = int'(win_idx);
        req_sh    = in_req >> j;
        icc_wr_sh = in_icc_wr >> j;
        tag_sh    = in_tag >> (j * TAG_W);
        val_sh    = in_val >> (j * DATA_W);
        icc_sh    = in_icc >> (j * 4);
    end

    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        val_d    = val_q;
        icc_d    = icc_q;
        gidx_d   = gidx_q;
        drop_d   = drop_q;
        ack_d    = '0;
        bcast_d  = 1'b0;
        icc_wr_d = 1'b0;
`ifndef CDB_ARB_FIXED_PRIO_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|in_req) begin
`ifndef CDB_ARB_FIXED_PRIO_EN
                    ptr_d = win_idx;
`endif
                    gidx_d = win_idx;
                    ack_d  = {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
                    if (tag_sh[TAG_W-1:0] != INVALID_TAG) begin
                        tag_d    = tag_sh[TAG_W-1:0];
                        val_d    = val_sh[DATA_W-1:0];
                        bcast_d  = 1'b1;
                        icc_wr_d = icc_wr_sh[0];
                        if (icc_wr_sh[0]) icc_d = icc_sh[3:0];
                        state_d  = BCAST;
                    end else begin
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                        state_d = DROP;
                    end
                end
            end
            // BCAST/DROP: a single cycle that forces the broadcast low, with
            // no arbitration in that cycle.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            bcast_q  <= 1'b0;
            tag_q    <= '0;
            val_q    <= '0;
            icc_q    <= '0;
            icc_wr_q <= 1'b0;
            gidx_q   <= '0;
            drop_q   <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
            // Start on the last source so that source 0 is searched first.
            ptr_q    <= IDX_W'(N_SRC - 1);
`endif
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            bcast_q  <= bcast_d;
            tag_q    <= tag_d;
            val_q    <= val_d;
            icc_q    <= icc_d;
            icc_wr_q <= icc_wr_d;
            gidx_q   <= gidx_d;
            drop_q   <= drop_d;
`ifndef CDB_ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign out_ack           = ack_q;
    assign out_CDB_broadcast = bcast_q;
    assign out_CDB_tag       = tag_q;
    assign out_CDB_val       = val_q;
    assign out_ICC_flags     = icc_q;
    assign out_ICC_wr        = icc_wr_q;
    assign out_grant_idx     = gidx_q;
    assign out_drop_cnt      = drop_q;

endmodule
